// File: rtl/main_tff_pkg.sv
// Shared types and helpers for the main_tff toggle flip-flop bank.
// Define MAIN_TFF_QN_EN to add the complementary Qn output.
`timescale 1ns/1ps
package main_tff_pkg;

    localparam int unsigned DEFAULT_WIDTH = 1;

    typedef logic state_t;

    function automatic state_t toggle(input state_t q, input state_t t);
        return q ^ t;
    endfunction

endpackage

// File: rtl/main_tff_cell.sv
// Single toggle flip-flop bit with asynchronous active-low clear to rst_val.
// Under MAIN_TFF_QN_EN the cell also exposes qn = ~q.
`timescale 1ns/1ps
module tff_cell
    import main_tff_pkg::*;
(
    input  logic clk,
    input  logic clr,
    input  logic t,
    input  logic rst_val,
`ifdef MAIN_TFF_QN_EN
    output logic q,
    output logic qn
`else
    output logic q
`endif
);

    state_t q_q;
    state_t q_d;

    always_comb begin
        q_d = toggle(q_q, t);
    end

    // Clear is asynchronous and dominates any pending toggle.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_q <= rst_val;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

`ifdef MAIN_TFF_QN_EN
    assign qn = ~q_q;
`endif

endmodule

// File: rtl/main_tff.sv
// WIDTH-bit bank of independent toggle flip-flops sharing clk and async clear.
// Define MAIN_TFF_QN_EN to add output Qn = ~Q (no extra flops).
`timescale 1ns/1ps
module main_tff
    import main_tff_pkg::*;
#(
    parameter int unsigned          WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] T,
`ifdef MAIN_TFF_QN_EN
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn
`else
    output logic [WIDTH-1:0] Q
`endif
);

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
        tff_cell u_cell (
            .clk     (clk),
            .clr     (clr),
            .t       (T[i]),
            .rst_val (RESET_VAL[i]),
`ifdef MAIN_TFF_QN_EN
            .q       (Q[i]),
            .qn      (Qn[i])
`else
            .q       (Q[i])
`endif
        );
    end

endmodule

// File: tb/tb_main_tff.sv
// Scoreboard bench for main_tff: a 1-bit and a 4-bit bank driven from one clock/clear.
`timescale 1ns/1ps
module tb_main_tff;

    typedef struct {
        int         id;
        logic       e1;
        logic [3:0] e4;
    } exp_t;

    logic       clk;
    logic       clr;
    logic [0:0] t1;
    logic [3:0] t4;
    logic [0:0] q1;
    logic [3:0] q4;
`ifdef MAIN_TFF_QN_EN
    logic [0:0] qn1;
    logic [3:0] qn4;
`endif

    exp_t exp_q[$];
    event sample_ev;
    int   checks = 0;
    int   errors = 0;
    int   sample_id = 0;

    main_tff #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
        .clk (clk),
        .clr (clr),
        .T   (t1),
`ifdef MAIN_TFF_QN_EN
        .Q   (q1),
        .Qn  (qn1)
`else
        .Q   (q1)
`endif
    );

    main_tff #(.WIDTH(4), .RESET_VAL(4'b0000)) dut4 (
        .clk (clk),
        .clr (clr),
        .T   (t4),
`ifdef MAIN_TFF_QN_EN
        .Q   (q4),
        .Qn  (qn4)
`else
        .Q   (q4)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    task automatic wait_until(input longint t);
        #(t - longint'($time));
    endtask

    task automatic expect_now(input logic e1, input logic [3:0] e4);
        exp_t e;
        e.id = sample_id;
        e.e1 = e1;
        e.e4 = e4;
        sample_id++;
        exp_q.push_back(e);
        -> sample_ev;
    endtask

    // Monitor: pops one expectation per sample event and compares it to the outputs.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sample_underflow at %0t: no expectation queued", $time);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (q1[0] !== e.e1) begin
                    errors++;
                    $display("FAIL s%0d_q1 at %0t: got %b want %b", e.id, $time, q1[0], e.e1);
                end
                checks++;
                if (q4 !== e.e4) begin
                    errors++;
                    $display("FAIL s%0d_q4 at %0t: got %b want %b", e.id, $time, q4, e.e4);
                end
`ifdef MAIN_TFF_QN_EN
                checks++;
                if (qn1[0] !== ~e.e1) begin
                    errors++;
                    $display("FAIL s%0d_qn1 at %0t: got %b want %b", e.id, $time, qn1[0], ~e.e1);
                end
                checks++;
                if (qn4 !== ~e.e4) begin
                    errors++;
                    $display("FAIL s%0d_qn4 at %0t: got %b want %b", e.id, $time, qn4, ~e.e4);
                end
`endif
            end
        end
    end

    // Stimulus with hand-computed expectations; posedges at 50, 150, 250, ...
    initial begin
        clr = 1'b0;
        t1  = 1'b0;
        t4  = 4'b0000;

        wait_until(10);   expect_now(1'b0, 4'b0000);   // held in clear
        wait_until(60);   expect_now(1'b0, 4'b0000);   // edge at 50 ignored under clear

        wait_until(100);  clr = 1'b1; t1 = 1'b0;
        wait_until(160);  expect_now(1'b0, 4'b0000);   // T=0 holds

        wait_until(200);  clr = 1'b0; t1 = 1'b1; t4 = 4'b1111;
        wait_until(260);  expect_now(1'b0, 4'b0000);   // clear beats toggle

        wait_until(300);  clr = 1'b1; t4 = 4'b0000;
        wait_until(360);  expect_now(1'b1, 4'b0000);
        wait_until(460);  expect_now(1'b0, 4'b0000);
        wait_until(560);  expect_now(1'b1, 4'b0000);

        wait_until(570);  clr = 1'b0;
        wait_until(575);  expect_now(1'b0, 4'b0000);   // async clear between edges

        wait_until(600);  clr = 1'b1; t1 = 1'b1;
        wait_until(660);  expect_now(1'b1, 4'b0000);

        wait_until(750);  clr = 1'b0;                   // clear coincident with posedge
        wait_until(760);  expect_now(1'b0, 4'b0000);

        wait_until(800);  clr = 1'b1; t1 = 1'b0; t4 = 4'b0101;
        wait_until(860);  expect_now(1'b0, 4'b0101);
        wait_until(960);  expect_now(1'b0, 4'b0000);

        wait_until(1000); t1 = 1'b1; t4 = 4'b0011;
        wait_until(1060); expect_now(1'b1, 4'b0011);
        wait_until(1100); t4 = 4'b1111;
        wait_until(1160); expect_now(1'b0, 4'b1100);

        wait_until(1180); clr = 1'b0; t1 = 1'bx; t4 = 4'bxxxx;
        wait_until(1190); expect_now(1'b0, 4'b0000);   // mid-cycle clear, bank of 4
        wait_until(1260); expect_now(1'b0, 4'b0000);   // unknown T under clear

        wait_until(1300);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
